// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared AHB types for the slave-side arbiter: transfer/burst encodings,
// arbiter states and the burst-length helper.
package ahb_arbiter_slave_pkg;

   localparam int unsigned BEAT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWN,
      ARB_BURST,
      ARB_INCR
   } arb_state_type;

   // Remaining beats after the NONSEQ (L-1); SINGLE and INCR both yield 0.
   function automatic logic [BEAT_W-1:0] burst_len(input hburst_type b);
      logic [BEAT_W-1:0] len;
      len = '0;
      case (b)
         WRAP4,  INCR4:  len = BEAT_W'(3);
         WRAP8,  INCR8:  len = BEAT_W'(7);
         WRAP16, INCR16: len = BEAT_W'(15);
         default:        len = '0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_arbiter_slave_if.sv
// Per-slave arbitration bus: master requests/transfer info in, grant and
// data-phase ownership out.
interface ahb_arbiter_slave_if
   import ahb_arbiter_slave_pkg::*;
#(
   parameter int unsigned SLAVE_X_MASTER_NUM = 3,
   parameter int unsigned MIDX_WIDTH         = $clog2(SLAVE_X_MASTER_NUM)
);
   logic [SLAVE_X_MASTER_NUM-1:0] hreq;
   htrans_type                    htrans [SLAVE_X_MASTER_NUM];
   hburst_type                    hburst [SLAVE_X_MASTER_NUM];
   logic                          hready;
   logic [SLAVE_X_MASTER_NUM-1:0] hgrant;
   logic [MIDX_WIDTH-1:0]         hmaster_addr;
   logic                          hsel;
   logic [MIDX_WIDTH-1:0]         hmaster_data;
   logic                          hdata_valid;

   modport slave (
      input  hreq, htrans, hburst, hready,
      output hgrant, hmaster_addr, hsel, hmaster_data, hdata_valid
   );

   modport master (
      output hreq, htrans, hburst, hready,
      input  hgrant, hmaster_addr, hsel, hmaster_data, hdata_valid
   );
endinterface

// File: rtl/ahb_arbiter_slave_rr_picker.sv
// Round-robin picker: first requester after rr_ptr, wrapping, so the
// previous owner ends up with the lowest priority.
module ahb_rr_picker #(
   parameter int unsigned SLAVE_X_MASTER_NUM = 3,
   parameter int unsigned MIDX_WIDTH         = $clog2(SLAVE_X_MASTER_NUM)
) (
   input  logic [SLAVE_X_MASTER_NUM-1:0] req,
   input  logic [MIDX_WIDTH-1:0]         rr_ptr,
   output logic [MIDX_WIDTH-1:0]         winner,
   output logic                          found
);
   int unsigned idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 1; k <= SLAVE_X_MASTER_NUM; k++) begin
         idx = (32'(rr_ptr) + k) % SLAVE_X_MASTER_NUM;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = MIDX_WIDTH'(idx);
         end
      end
   end
endmodule

// File: rtl/ahb_arbiter_slave.sv
// Slave-side AHB arbiter: round-robin grant held across fixed and undefined
// bursts, plus data-phase owner tracking for the slave write/read mux.
module ahb_arbiter_slave
   import ahb_arbiter_slave_pkg::*;
#(
   parameter int unsigned SLAVE_X_MASTER_NUM = 3,
   parameter int unsigned MIDX_WIDTH         = $clog2(SLAVE_X_MASTER_NUM)
) (
   input logic               hclk,
   input logic               hreset_n,
   ahb_arbiter_slave_if.slave bus
);
   arb_state_type                 state, state_n;
   logic [SLAVE_X_MASTER_NUM-1:0] grant_q, grant_n;
   logic [MIDX_WIDTH-1:0]         addr_q, addr_n;
   logic [MIDX_WIDTH-1:0]         rr_ptr, rr_ptr_n;
   logic [BEAT_W-1:0]             beat_cnt, beat_cnt_n;
   logic [MIDX_WIDTH-1:0]         data_q;
   logic                          valid_q;

   htrans_type            tr_g;
   hburst_type            bu_g;
   logic                  active;
   logic                  accept;
   logic                  start_nonseq;
   logic                  rearb;
   logic [MIDX_WIDTH-1:0] winner;
   logic                  found;

   ahb_rr_picker #(
      .SLAVE_X_MASTER_NUM (SLAVE_X_MASTER_NUM),
      .MIDX_WIDTH         (MIDX_WIDTH)
   ) u_picker (
      .req    (bus.hreq),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .found  (found)
   );

   assign tr_g         = bus.htrans[addr_q];
   assign bu_g         = bus.hburst[addr_q];
   assign active       = (|grant_q) && (tr_g == NONSEQ || tr_g == SEQ);
   assign accept       = bus.hready && active;
   assign start_nonseq = accept && (tr_g == NONSEQ);

   // Next-state: a NONSEQ from the owner always (re)starts burst tracking.
   always_comb begin
      state_n    = state;
      grant_n    = grant_q;
      addr_n     = addr_q;
      rr_ptr_n   = rr_ptr;
      beat_cnt_n = beat_cnt;
      rearb      = 1'b0;

      if (bus.hready) begin
         if (start_nonseq) begin
            if (bu_g == INCR) begin
               beat_cnt_n = '0;
               state_n    = ARB_INCR;
            end else if (burst_len(bu_g) != '0) begin
               beat_cnt_n = burst_len(bu_g);
               state_n    = ARB_BURST;
            end else begin
               beat_cnt_n = '0;
               rearb      = 1'b1;
            end
         end else begin
            case (state)
               ARB_IDLE:  rearb = 1'b1;
               ARB_OWN:   rearb = !bus.hreq[addr_q];
               ARB_BURST: begin
                  if (accept && tr_g == SEQ) begin
                     if (beat_cnt > BEAT_W'(1)) begin
                        beat_cnt_n = beat_cnt - BEAT_W'(1);
                     end else begin
                        beat_cnt_n = '0;
                        rearb      = 1'b1;
                     end
                  end else if (tr_g == IDLE) begin
                     beat_cnt_n = '0;
                     rearb      = 1'b1;
                  end
               end
               ARB_INCR:  rearb = (tr_g == IDLE);
               default:   state_n = ARB_IDLE;
            endcase
         end
      end

      if (rearb) begin
         if (found) begin
            grant_n         = '0;
            grant_n[winner] = 1'b1;
            addr_n          = winner;
            rr_ptr_n        = winner;
            state_n         = ARB_OWN;
         end else begin
            grant_n = '0;
            state_n = ARB_IDLE;
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         state    <= ARB_IDLE;
         grant_q  <= '0;
         addr_q   <= '0;
         rr_ptr   <= MIDX_WIDTH'(SLAVE_X_MASTER_NUM - 1);
         beat_cnt <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_n;
         grant_q  <= grant_n;
         addr_q   <= addr_n;
         rr_ptr   <= rr_ptr_n;
         beat_cnt <= beat_cnt_n;
         if (bus.hready) begin
            data_q  <= addr_q;
            valid_q <= accept;
         end
      end
   end

   assign bus.hgrant       = grant_q;
   assign bus.hmaster_addr = addr_q;
   assign bus.hsel         = active;
   assign bus.hmaster_data = data_q;
   assign bus.hdata_valid  = valid_q;
endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed bench for ahb_arbiter_slave: reset, round robin, fixed/undefined
// bursts, wait states, early termination, mid-burst reset, single requester.
module tb_ahb_arbiter_slave;
   import ahb_arbiter_slave_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   ahb_arbiter_slave_if #(.SLAVE_X_MASTER_NUM(3)) bus ();

   ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(3)) dut (
      .hclk     (clk),
      .hreset_n (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Decoder behaviour: request follows a non-IDLE transfer.
   always_comb begin
      bus.hreq = '0;
      for (int i = 0; i < 3; i++) bus.hreq[i] = (bus.htrans[i] != IDLE);
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         tests++;
         assert ($onehot0(bus.hgrant)) else begin
            fails++;
            $error("FAIL onehot: observed hgrant=%b required at most one bit", bus.hgrant);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input int i, input htrans_type t, input hburst_type b);
      bus.htrans[i] = t;
      bus.hburst[i] = b;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] g, input logic [1:0] a,
                          input logic [1:0] d, input logic v);
      chk({tag, ".hgrant"},       32'(bus.hgrant),       32'(g));
      chk({tag, ".hmaster_addr"}, 32'(bus.hmaster_addr), 32'(a));
      chk({tag, ".hmaster_data"}, 32'(bus.hmaster_data), 32'(d));
      chk({tag, ".hdata_valid"},  32'(bus.hdata_valid),  32'(v));
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.hready = 1'b1;
      for (int i = 0; i < 3; i++) set(i, NONSEQ, SINGLE);

      // reset with all masters requesting
      step(); step();
      chk_out("rst", 3'b000, 2'd0, 2'd0, 1'b0);
      chk("rst.beat", 32'(dut.beat_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      chk_out("rel", 3'b001, 2'd0, 2'd0, 1'b0);
      chk("rel.hsel", 32'(bus.hsel), 32'd1);

      // round robin over SINGLE transfers
      step(); chk_out("rr1", 3'b010, 2'd1, 2'd0, 1'b1);
      step(); chk_out("rr2", 3'b100, 2'd2, 2'd1, 1'b1);
      step(); chk_out("rr3", 3'b001, 2'd0, 2'd2, 1'b1);

      // wait states hold everything
      bus.hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(); chk_out("ws", 3'b001, 2'd0, 2'd2, 1'b1);
      end
      bus.hready = 1'b1;
      step(); chk_out("ws_end", 3'b010, 2'd1, 2'd0, 1'b1);

      // master1 INCR4 with a BUSY beat and a wait state, master0 requesting
      set(1, NONSEQ, INCR4); set(2, IDLE, SINGLE);
      step(); chk_out("b4_nseq", 3'b010, 2'd1, 2'd1, 1'b1);
      chk("b4_nseq.beat", 32'(dut.beat_cnt), 32'd3);
      set(1, SEQ, INCR4);
      step(); chk_out("b4_s1", 3'b010, 2'd1, 2'd1, 1'b1);
      set(1, BUSY, INCR4);
      step(); chk_out("b4_busy", 3'b010, 2'd1, 2'd1, 1'b0);
      chk("b4_busy.hsel", 32'(bus.hsel), 32'd0);
      set(1, SEQ, INCR4); bus.hready = 1'b0;
      step(); chk_out("b4_wait", 3'b010, 2'd1, 2'd1, 1'b0);
      bus.hready = 1'b1;
      step(); chk_out("b4_s2", 3'b010, 2'd1, 2'd1, 1'b1);
      step(); chk_out("b4_s3", 3'b001, 2'd0, 2'd1, 1'b1);

      // master2 undefined-length INCR burst
      set(0, IDLE, SINGLE); set(1, IDLE, SINGLE); set(2, NONSEQ, INCR);
      step(); chk_out("incr_arb", 3'b100, 2'd2, 2'd0, 1'b0);
      set(0, NONSEQ, SINGLE);
      step(); chk_out("incr_nseq", 3'b100, 2'd2, 2'd2, 1'b1);
      set(2, SEQ, INCR);
      for (int k = 0; k < 5; k++) begin
         step(); chk_out("incr_seq", 3'b100, 2'd2, 2'd2, 1'b1);
      end
      set(2, IDLE, INCR);
      step(); chk_out("incr_end", 3'b001, 2'd0, 2'd2, 1'b0);

      // master0 WRAP8 terminated early after three beats
      set(0, NONSEQ, WRAP8); set(2, NONSEQ, SINGLE);
      step(); chk_out("w8_nseq", 3'b001, 2'd0, 2'd0, 1'b1);
      chk("w8_nseq.beat", 32'(dut.beat_cnt), 32'd7);
      set(0, SEQ, WRAP8);
      step(); step(); chk_out("w8_s2", 3'b001, 2'd0, 2'd0, 1'b1);
      chk("w8_s2.beat", 32'(dut.beat_cnt), 32'd5);
      set(0, IDLE, WRAP8);
      step(); chk_out("w8_term", 3'b100, 2'd2, 2'd0, 1'b0);
      chk("w8_term.beat", 32'(dut.beat_cnt), 32'd0);

      // reset in the middle of an INCR8 burst
      set(2, NONSEQ, INCR8);
      step(); chk_out("b8_nseq", 3'b100, 2'd2, 2'd2, 1'b1);
      set(2, SEQ, INCR8);
      step(); chk("b8_s1.beat", 32'(dut.beat_cnt), 32'd6);
      rst_n = 1'b0;
      step(); chk_out("mid_rst", 3'b000, 2'd0, 2'd0, 1'b0);
      chk("mid_rst.beat", 32'(dut.beat_cnt), 32'd0);

      // lone requester is re-granted back to back
      set(2, IDLE, SINGLE); set(0, NONSEQ, SINGLE);
      rst_n = 1'b1;
      step(); chk_out("single0", 3'b001, 2'd0, 2'd0, 1'b0);
      step(); chk_out("single1", 3'b001, 2'd0, 2'd0, 1'b1);
      step(); chk_out("single2", 3'b001, 2'd0, 2'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
